lut_function_unit: RTL and testbench

Programmable, pipelined successor to the fixed three-input logic function `f = x | (~y & z)`. It evaluates one NIN-input Boolean function across LANES independent lanes per beat, using a 2^NIN-entry truth table. The table resets to that same function and can be reloaded serially at run time. Data moves through a one-stage registered valid/ready pipeline, so the unit drops into the lab datapath between any two handshaked stages.

---
 rtl/lut_function_unit.sv | 170 +++++++++++++++++
 tb/tb_lut_function_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_function_unit.sv
// lut_function_unit: LANES-wide evaluation of one NIN-input Boolean function
// through a 2^NIN-entry truth table. The table resets to DEFAULT_TT
// (8'hF2 = x | (~y & z)) and can be reloaded serially, MSB entry first, via
// cfg_load/cfg_bit. Results leave through a one-stage valid/ready register.
// Optional feature macro: LUT_STATS_EN adds a saturating 16-bit beat_count
// that counts accepted beats and clears whenever a new table commits.
module lut_function_unit #(
    parameter int unsigned         NIN        = 3,
    parameter int unsigned         LANES      = 8,
    parameter logic [(1<<NIN)-1:0] DEFAULT_TT = 8'hF2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*NIN-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_data,
    input  logic                 cfg_load,
    input  logic                 cfg_bit,
    output logic                 cfg_done,
    output logic                 cfg_abort
`ifdef LUT_STATS_EN
    ,
    output logic [15:0]          beat_count
`endif
);

    localparam int unsigned  TTW      = 1 << NIN;
    localparam logic [NIN:0] CNT_FULL = TTW[NIN:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } cfg_state_t;

    cfg_state_t       r_state;
    cfg_state_t       w_state_nxt;
    logic [NIN:0]     r_count;
    logic [NIN:0]     w_count_nxt;
    logic [NIN:0]     w_count_inc;
    logic [TTW-1:0]   r_shadow;
    logic [TTW-1:0]   w_shadow_nxt;
    logic [TTW-1:0]   r_tt;
    logic             r_cfg_done;
    logic             r_cfg_abort;
    logic             w_done_nxt;
    logic             w_abort_nxt;
    logic             w_commit;

    logic             r_out_valid;
    logic [LANES-1:0] r_out_data;
    logic [LANES-1:0] w_lookup;
    logic             w_accept;

    assign w_count_inc = r_count + 1'b1;

    // Config FSM state, shadow shift register, active table and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_shadow    <= '0;
            r_tt        <= DEFAULT_TT;
            r_cfg_done  <= 1'b0;
            r_cfg_abort <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_shadow    <= w_shadow_nxt;
            r_cfg_done  <= w_done_nxt;
            r_cfg_abort <= w_abort_nxt;
            if (w_commit) begin
                r_tt <= r_shadow;
            end
        end
    end

    // Config FSM next state; cfg_done is registered on entry to COMMIT so it
    // is high during the COMMIT cycle, while the table swaps at that cycle's end.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_shadow_nxt = r_shadow;
        w_done_nxt   = 1'b0;
        w_abort_nxt  = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_load) begin
                    w_shadow_nxt = {r_shadow[TTW-2:0], cfg_bit};
                    w_count_nxt  = {{NIN{1'b0}}, 1'b1};
                    w_state_nxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cfg_load) begin
                    w_shadow_nxt = {r_shadow[TTW-2:0], cfg_bit};
                    w_count_nxt  = w_count_inc;
                    if (w_count_inc == CNT_FULL) begin
                        w_state_nxt = S_COMMIT;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_shadow_nxt = '0;
                    w_count_nxt  = '0;
                    w_abort_nxt  = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_count_nxt = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Per-lane table lookup of the incoming operands.
    always_comb begin
        w_lookup = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_lookup[i] = r_tt[in_data[i*NIN +: NIN]];
        end
    end

    // Output stage: capture on accept, drain on out_ready, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_lookup;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign cfg_done  = r_cfg_done;
    assign cfg_abort = r_cfg_abort;

`ifdef LUT_STATS_EN
    logic [15:0] r_beat_count;

    // Accepted-beat counter, saturating; a table commit restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_count <= '0;
        end else if (r_cfg_done) begin
            r_beat_count <= '0;
        end else if (w_accept && (r_beat_count != '1)) begin
            r_beat_count <= r_beat_count + 1'b1;
        end
    end

    assign beat_count = r_beat_count;
`endif

endmodule

// File: tb/tb_lut_function_unit.sv
// Directed bench for lut_function_unit (default NIN=3, LANES=8).
// Define LUT_STATS_EN for both files to exercise beat_count.
module tb_lut_function_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        cfg_load;
    logic        cfg_bit;
    logic        cfg_done;
    logic        cfg_abort;
`ifdef LUT_STATS_EN
    logic [15:0] beat_count;
`endif

    int unsigned n_checks;
    int unsigned n_errors;

    // lane i = i, and every lane = 3
    localparam logic [23:0] LANE_IDX = 24'hFAC688;
    localparam logic [23:0] LANE_3   = 24'h6DB6DB;

    lut_function_unit #(
        .NIN        (3),
        .LANES      (8),
        .DEFAULT_TT (8'hF2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_load   (cfg_load),
        .cfg_bit    (cfg_bit),
        .cfg_done   (cfg_done),
        .cfg_abort  (cfg_abort)
`ifdef LUT_STATS_EN
        ,
        .beat_count (beat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input logic [7:0] tt);
        for (int k = 7; k >= 0; k--) begin
            cfg_load = 1'b1;
            cfg_bit  = tt[k];
            tick();
            if (k > 0) check("cfg_done_during_load", 32'(cfg_done), 32'd0);
        end
        cfg_load = 1'b0;
        cfg_bit  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cfg_load  = 1'b0;
        cfg_bit   = 1'b0;

        // Reset values
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_cfg_done",  32'(cfg_done),  32'd0);
        check("rst_cfg_abort", 32'(cfg_abort), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        tick();
        rst_n = 1'b1;
`ifdef LUT_STATS_EN
        check("rst_beat_count", 32'(beat_count), 32'd0);
`endif

        // Default table, lane i = i
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = LANE_IDX;
        tick();
        check("beat1_valid", 32'(out_valid), 32'd1);
        check("beat1_data",  32'(out_data),  32'hF2);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = LANE_IDX;
        tick();
        check("bp_first_valid", 32'(out_valid), 32'd1);
        check("bp_first_data",  32'(out_data),  32'hF2);
        check("bp_in_ready",    32'(in_ready),  32'd0);
        in_data = LANE_3;
        tick();
        check("bp_hold1_data",  32'(out_data),  32'hF2);
        check("bp_hold1_ready", 32'(in_ready),  32'd0);
        tick();
        check("bp_hold2_data",  32'(out_data),  32'hF2);
        check("bp_hold2_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_data",  32'(out_data),  32'h00);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", 32'(out_valid), 32'd0);

        // Aborted partial load: 5 zero bits, then cfg_load drops
        for (int k = 0; k < 5; k++) begin
            cfg_load = 1'b1;
            cfg_bit  = 1'b0;
            tick();
        end
        cfg_load = 1'b0;
        check("abort_not_yet", 32'(cfg_abort), 32'd0);
        tick();
        check("abort_pulse", 32'(cfg_abort), 32'd1);
        check("abort_no_done", 32'(cfg_done), 32'd0);
        tick();
        check("abort_pulse_end", 32'(cfg_abort), 32'd0);
        in_valid = 1'b1;
        in_data  = LANE_IDX;
        tick();
        check("abort_table_kept", 32'(out_data), 32'hF2);
        in_valid = 1'b0;
        tick();

        // Full load of 8'h96, beat in COMMIT cycle still sees old table
        load_table(8'h96);
        check("load_done_pulse", 32'(cfg_done),  32'd1);
        check("load_no_abort",   32'(cfg_abort), 32'd0);
        in_valid = 1'b1;
        in_data  = LANE_IDX;
        tick();
        check("commit_beat_old_table", 32'(out_data), 32'hF2);
        check("done_pulse_end",        32'(cfg_done), 32'd0);
        tick();
        check("new_table_idx", 32'(out_data), 32'h96);
        in_data = LANE_3;
        tick();
        check("new_table_lane3", 32'(out_data), 32'h00);
        in_valid = 1'b0;
        tick();

        // Reset during a reload: table reverts to default
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = LANE_IDX;
        tick();
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cfg_load = 1'b1;
            cfg_bit  = k[0];
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("midload_rst_valid", 32'(out_valid), 32'd0);
        check("midload_rst_ready", 32'(in_ready),  32'd1);
        check("midload_rst_done",  32'(cfg_done),  32'd0);
        cfg_load = 1'b0;
        tick();
        check("midload_rst_abort", 32'(cfg_abort), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = LANE_IDX;
        tick();
        check("post_rst_table", 32'(out_data), 32'hF2);
        check("post_rst_abort", 32'(cfg_abort), 32'd0);
        check("post_rst_done",  32'(cfg_done),  32'd0);

`ifdef LUT_STATS_EN
        check("stats_one", 32'(beat_count), 32'd1);
        tick();
        tick();
        check("stats_three", 32'(beat_count), 32'd3);
        in_valid = 1'b0;
        tick();
        check("stats_idle_hold", 32'(beat_count), 32'd3);
        load_table(8'hF2);
        check("stats_load_done", 32'(cfg_done), 32'd1);
        tick();
        check("stats_cleared", 32'(beat_count), 32'd0);
`endif
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
